// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, response status codes and initiator state encoding.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_ERR        = 2'd1,
    RSP_TIMEOUT    = 2'd2,
    RSP_RETRY_FAIL = 2'd3
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RETRY,
    ST_RESP
  } wb_state_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timer.sv
// Bus-cycle watchdog: counts enabled cycles and flags the cycle on which the limit is reached.
module wb_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Saturates at LIMIT; a zero limit disables counting entirely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT_CYCLES != 0) && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT - 1'b1);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one cyc/stb transfer
// (with retry and timeout handling), one response out.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic              cmd_we_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic [1:0]        rsp_status_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              we_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              rty_i
);

  localparam int RW = cnt_width(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  wb_state_e     state;
  logic [RW-1:0] retry_cnt;
  logic          timed_out;

  // The watchdog only runs while a strobe is outstanding and restarts for every attempt.
  wb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state != ST_ACTIVE),
    .enable (state == ST_ACTIVE),
    .expired(timed_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      retry_cnt    <= '0;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= RSP_OK;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      adr_o        <= '0;
      sel_o        <= '0;
      we_o         <= 1'b0;
      dat_o        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            adr_o       <= cmd_adr_i;
            sel_o       <= cmd_sel_i;
            we_o        <= cmd_we_i;
            dat_o       <= cmd_we_i ? cmd_dat_i : '0;
            cyc_o       <= 1'b1;
            stb_o       <= 1'b1;
            retry_cnt   <= '0;
            state       <= ST_ACTIVE;
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end

        // err outranks rty, which outranks ack, when a responder raises several at once.
        ST_ACTIVE: begin
          if (err_i) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_ERR;
            rsp_dat_o    <= '0;
            state        <= ST_RESP;
          end else if (rty_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            if (retry_cnt == RETRY_LIMIT) begin
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= RSP_RETRY_FAIL;
              rsp_dat_o    <= '0;
              state        <= ST_RESP;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_RETRY;
            end
          end else if (ack_i) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_OK;
            rsp_dat_o    <= we_o ? '0 : dat_i;
            state        <= ST_RESP;
          end else if (timed_out) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_TIMEOUT;
            rsp_dat_o    <= '0;
            state        <= ST_RESP;
          end
        end

        ST_RETRY: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          state <= ST_ACTIVE;
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= RSP_OK;
            adr_o        <= '0;
            sel_o        <= '0;
            we_o         <= 1'b0;
            dat_o        <= '0;
            cmd_ready_o  <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: gpio-like register at 0x100 plus a scripted responder.
module tb_wb_initiator;
  import wb_pkg::*;

  localparam int TO   = 255;
  localparam int MAXR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ERRACK = 3, K_NONE = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_adr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_sel_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  always #5 clk_i = ~clk_i;

  wb_initiator #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_we_i    (cmd_we_i),
    .cmd_sel_i   (cmd_sel_i),
    .cmd_dat_i   (cmd_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .adr_o       (adr_o),
    .sel_o       (sel_o),
    .we_o        (we_o),
    .dat_o       (dat_o),
    .dat_i       (dat_i),
    .ack_i       (ack_i),
    .err_i       (err_i),
    .rty_i       (rty_i)
  );

  // Responder: attempt N of a transfer follows script entry N (last entry repeats).
  int          kind_q[8];
  int          delay_q[8];
  int          n_script = 1;
  int          rty_total = 0;
  int          rty_base = 0;
  int          wait_cnt = 0;
  logic        stray_en = 1'b0;
  logic [7:0]  pin_output = 8'h00;
  logic [7:0]  pin_input = 8'h00;
  logic [31:0] stub_rdata = '0;
  int          attempt_idx, cur_kind, cur_delay;
  logic        hit;

  always_comb begin
    attempt_idx = rty_total - rty_base;
    if (attempt_idx > n_script - 1) attempt_idx = n_script - 1;
    cur_kind  = kind_q[attempt_idx];
    cur_delay = delay_q[attempt_idx];
    hit   = cyc_o && stb_o && (wait_cnt == cur_delay) && (cur_kind != K_NONE);
    ack_i = (hit && (cur_kind == K_ACK || cur_kind == K_ERRACK)) || (stray_en && !stb_o);
    err_i = hit && (cur_kind == K_ERR || cur_kind == K_ERRACK);
    rty_i = hit && (cur_kind == K_RTY);
    dat_i = (adr_o == 32'h100) ? {16'h0000, pin_input, pin_output} : stub_rdata;
  end

  always @(posedge clk_i) begin
    wait_cnt <= stb_o ? wait_cnt + 1 : 0;
    if (stb_o && rty_i) rty_total <= rty_total + 1;
    if (stb_o && ack_i && !err_i && !rty_i && we_o && adr_o == 32'h100 && sel_o[0])
      pin_output <= dat_o[7:0];
  end

  // Bus monitor: strobe-high cycles, strobe rises, rises after a gap longer than one cycle.
  int          stb_cnt = 0, rise_cnt = 0, long_rise_cnt = 0, low_run = 100, hold_bad = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] cur_adr = '0;
  logic        cur_we = 1'b0;

  always @(negedge clk_i) begin
    if (stb_o) begin
      stb_cnt++;
      if (!prev_stb) begin
        rise_cnt++;
        if (low_run != 1) long_rise_cnt++;
      end
      low_run = 0;
      if (adr_o !== cur_adr || (!cur_we && dat_o !== 32'h0)) hold_bad++;
    end else begin
      low_run++;
    end
    prev_stb = stb_o;
  end

  int          nchecks = 0, nfail = 0;
  logic [1:0]  obs_status, exp_status;
  logic [31:0] obs_dat, exp_dat;
  int          obs_lat, obs_stb, obs_rises, obs_long, obs_wait, obs_unstable, obs_busy_ready;
  int          exp_stb, exp_attempts;
  logic        obs_hung, obs_cyc_at_rsp, obs_ready_after, obs_valid_after;

  // Reference outcome of one transfer computed from the responder script.
  task automatic model(input bit we, input logic [31:0] rdata);
    bit done = 0;
    exp_stb = 0; exp_attempts = 0; exp_dat = '0; exp_status = RSP_OK;
    for (int a = 0; a < 16 && !done; a++) begin
      int idx = (a < n_script) ? a : n_script - 1;
      int k = kind_q[idx];
      int d = delay_q[idx];
      exp_attempts++;
      if (k == K_NONE || d >= TO) begin
        exp_stb += TO; exp_status = RSP_TIMEOUT; done = 1;
      end else begin
        exp_stb += d + 1;
        if (k == K_ERR || k == K_ERRACK) begin
          exp_status = RSP_ERR; done = 1;
        end else if (k == K_RTY) begin
          if (a == MAXR) begin exp_status = RSP_RETRY_FAIL; done = 1; end
        end else begin
          exp_status = RSP_OK; done = 1;
          if (!we) exp_dat = rdata;
        end
      end
    end
  endtask

  // Drives one command and collects what the DUT did; called at #1 after a rising edge.
  task automatic run_txn(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                         input logic [31:0] dat, input int hold);
    int s0, r0, l0, h0;
    obs_hung = 1'b0; obs_unstable = 0; obs_busy_ready = 0; obs_wait = 0;
    while (!cmd_ready_o && obs_wait < 50) begin @(posedge clk_i); #1; obs_wait++; end
    if (!cmd_ready_o) begin obs_hung = 1'b1; return; end
    rty_base = rty_total; cur_adr = adr; cur_we = we;
    s0 = stb_cnt; r0 = rise_cnt; l0 = long_rise_cnt; h0 = hold_bad;
    cmd_valid_i = 1'b1; cmd_adr_i = adr; cmd_we_i = we; cmd_sel_i = sel; cmd_dat_i = dat;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_dat_i = $urandom;
    obs_lat = 1;
    while (!rsp_valid_o && obs_lat < 3000) begin @(posedge clk_i); #1; obs_lat++; end
    if (!rsp_valid_o) begin obs_hung = 1'b1; return; end
    obs_status = rsp_status_o; obs_dat = rsp_dat_o; obs_cyc_at_rsp = cyc_o;
    repeat (hold) begin
      @(posedge clk_i); #1;
      if (rsp_status_o !== obs_status || rsp_dat_o !== obs_dat || rsp_valid_o !== 1'b1) obs_unstable++;
      if (cmd_ready_o !== 1'b0) obs_busy_ready++;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    obs_ready_after = cmd_ready_o; obs_valid_after = rsp_valid_o;
    obs_stb = stb_cnt - s0; obs_rises = rise_cnt - r0; obs_long = long_rise_cnt - l0;
    obs_unstable += hold_bad - h0;
  endtask

  task automatic set_script1(input int k, input int d);
    n_script = 1; kind_q[0] = k; delay_q[0] = d;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    #1;
    nchecks++;
    if ({cmd_ready_o, rsp_valid_o, cyc_o, stb_o, we_o, rsp_status_o, sel_o, adr_o, dat_o, rsp_dat_o} !== '0) begin
      nfail++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b cyc=%b stb=%b adr=%h required all zero",
               cmd_ready_o, rsp_valid_o, cyc_o, stb_o, adr_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_gpio_write;
    set_script1(K_ACK, 0);
    run_txn(32'h100, 1'b1, 4'hF, 32'h0000_005A, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_OK || obs_dat !== 32'h0) begin
      nfail++; $display("[TB] FAIL gpio_write_rsp: got status=%0d dat=%h required 0/0", obs_status, obs_dat);
    end
    nchecks++;
    if (obs_lat !== 2) begin nfail++; $display("[TB] FAIL gpio_write_latency: got %0d required 2", obs_lat); end
    nchecks++;
    if (pin_output !== 8'h5A) begin nfail++; $display("[TB] FAIL gpio_pin_output: got %h required 5a", pin_output); end
    nchecks++;
    if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) begin
      nfail++; $display("[TB] FAIL ready_after_handshake: got ready=%b valid=%b required 1/0", obs_ready_after, obs_valid_after);
    end
  endtask

  task automatic test_gpio_read;
    pin_input = 8'hC3;
    set_script1(K_ACK, 0);
    run_txn(32'h100, 1'b0, 4'hF, 32'h0, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_OK || obs_dat !== 32'h0000_C35A) begin
      nfail++; $display("[TB] FAIL gpio_read: got status=%0d dat=%h required 0/0000c35a", obs_status, obs_dat);
    end
    nchecks++;
    if (obs_cyc_at_rsp !== 1'b0) begin nfail++; $display("[TB] FAIL cyc_after_ack: got %b required 0", obs_cyc_at_rsp); end
  endtask

  task automatic test_timeout;
    set_script1(K_NONE, 0);
    run_txn(32'h200, 1'b0, 4'hF, 32'h0, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_TIMEOUT || obs_dat !== 32'h0) begin
      nfail++; $display("[TB] FAIL timeout_rsp: got status=%0d dat=%h required 2/0", obs_status, obs_dat);
    end
    nchecks++;
    if (obs_stb !== 255) begin nfail++; $display("[TB] FAIL timeout_stb_cycles: got %0d required 255", obs_stb); end
  endtask

  task automatic test_retry;
    n_script = 3;
    kind_q[0] = K_RTY; delay_q[0] = 0;
    kind_q[1] = K_RTY; delay_q[1] = 1;
    kind_q[2] = K_ACK; delay_q[2] = 2;
    stub_rdata = $urandom;
    model(1'b0, stub_rdata);
    run_txn(32'h4000, 1'b0, 4'h3, 32'h0, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_OK || obs_dat !== stub_rdata) begin
      nfail++; $display("[TB] FAIL retry_then_ack: got status=%0d dat=%h required 0/%h", obs_status, obs_dat, stub_rdata);
    end
    nchecks++;
    if (obs_rises !== 3 || obs_long !== 1 || obs_stb !== exp_stb) begin
      nfail++; $display("[TB] FAIL retry_gaps: got rises=%0d long=%0d stb=%0d required 3/1/%0d", obs_rises, obs_long, obs_stb, exp_stb);
    end
    set_script1(K_RTY, $urandom_range(0, 3));
    model(1'b1, stub_rdata);
    run_txn(32'h4004, 1'b1, 4'hF, $urandom, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_RETRY_FAIL || obs_rises !== MAXR + 1 || obs_stb !== exp_stb) begin
      nfail++; $display("[TB] FAIL retry_fail: got status=%0d attempts=%0d stb=%0d required 3/%0d/%0d",
                        obs_status, obs_rises, obs_stb, MAXR + 1, exp_stb);
    end
  endtask

  task automatic test_err_hold;
    set_script1(K_ERRACK, $urandom_range(0, 4));
    stub_rdata = $urandom;
    run_txn(32'h5000, 1'b0, 4'hF, 32'h0, 10);
    nchecks++;
    if (obs_hung || obs_status !== RSP_ERR || obs_dat !== 32'h0) begin
      nfail++; $display("[TB] FAIL err_priority: got status=%0d dat=%h required 1/0", obs_status, obs_dat);
    end
    nchecks++;
    if (obs_unstable !== 0 || obs_busy_ready !== 0) begin
      nfail++; $display("[TB] FAIL rsp_hold: got unstable=%0d ready_high=%0d required 0/0", obs_unstable, obs_busy_ready);
    end
    set_script1(K_ACK, 0);
    run_txn(32'h5004, 1'b1, 4'hF, 32'h1234_5678, 0);
    nchecks++;
    if (obs_hung || obs_wait !== 0 || obs_status !== RSP_OK) begin
      nfail++; $display("[TB] FAIL accept_after_handshake: got wait=%0d status=%0d required 0/0", obs_wait, obs_status);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    set_script1(K_NONE, 0);
    while (!cmd_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    cur_adr = 32'h300; cur_we = 1'b1;
    cmd_valid_i = 1'b1; cmd_adr_i = 32'h300; cmd_we_i = 1'b1; cmd_sel_i = 4'hF; cmd_dat_i = 32'hA5;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    nchecks++;
    if (stb_o !== 1'b1) begin nfail++; $display("[TB] FAIL stb_before_reset: got %b required 1", stb_o); end
    #2 rst_i = 1'b1;
    #1;
    nchecks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      nfail++; $display("[TB] FAIL async_reset_drop: got cyc=%b stb=%b required 0/0", cyc_o, stb_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    nchecks++;
    if (rsp_valid_o !== 1'b0) begin nfail++; $display("[TB] FAIL no_rsp_after_reset: got %b required 0", rsp_valid_o); end
    set_script1(K_ACK, 0);
    run_txn(32'h100, 1'b1, 4'h1, 32'h0000_0033, 0);
    nchecks++;
    if (obs_hung || obs_status !== RSP_OK || pin_output !== 8'h33) begin
      nfail++; $display("[TB] FAIL write_after_reset: got status=%0d pin=%h required 0/33", obs_status, pin_output);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      logic        we;
      logic [31:0] adr;
      n_script = $urandom_range(1, 4);
      for (int i = 0; i < n_script; i++) begin
        kind_q[i]  = ($urandom_range(0, 19) == 0) ? K_NONE : int'($urandom_range(0, 3));
        delay_q[i] = $urandom_range(0, 4);
      end
      we = 1'($urandom);
      adr = $urandom | 32'h1000;
      stub_rdata = $urandom;
      stray_en = 1'($urandom);
      model(we, stub_rdata);
      run_txn(adr, we, 4'($urandom), $urandom, $urandom_range(0, 3));
      stray_en = 1'b0;
      nchecks++;
      if (obs_hung || obs_status !== exp_status || obs_dat !== exp_dat) begin
        nfail++; $display("[TB] FAIL random_rsp[%0d]: got status=%0d dat=%h required %0d/%h", t, obs_status, obs_dat, exp_status, exp_dat);
      end
      nchecks++;
      if (obs_stb !== exp_stb || obs_rises !== exp_attempts || obs_long !== 1 || obs_unstable !== 0) begin
        nfail++; $display("[TB] FAIL random_bus[%0d]: got stb=%0d att=%0d long=%0d unstable=%0d required %0d/%0d/1/0",
                          t, obs_stb, obs_rises, obs_long, obs_unstable, exp_stb, exp_attempts);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin kind_q[i] = K_ACK; delay_q[i] = 0; end
    test_reset;
    test_gpio_write;
    test_gpio_read;
    test_timeout;
    test_retry;
    test_err_hold;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
